// File: rtl/modulo_escalonador_contador.sv
// Scheduler in front of a loadable counter: two requesters share a FIFO of presets
// through a round-robin arbiter, and a Moore FSM runs one load/count/clear job per entry.
module modulo_escalonador_contador #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    input  logic             cnt_zero,
    output logic             Load_C,
    output logic             Enable_C,
    output logic             Clear_Reg,
    output logic [WIDTH-1:0] cnt_value,
    output logic             full,
    output logic             empty,
    output logic [1:0]       state
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10,
        CLEAR = 2'b11
    } state_t;

    state_t           cur_state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      occupancy;
    logic             prio_b;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept_ok;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    // Acks are combinational; reset is folded in so nothing is granted while held in reset.
    assign accept_ok = rst & enable & ~full;
    assign ack_a     = accept_ok & req_a & (~req_b | ~prio_b);
    assign ack_b     = accept_ok & req_b & (~req_a |  prio_b);
    assign push      = ack_a | ack_b;
    assign push_data = ack_a ? data_a : data_b;
    assign pop       = enable & (cur_state == LOAD);

    assign full      = (occupancy == FULL_CNT);
    assign empty     = (occupancy == '0);
    assign state     = cur_state;

    assign Load_C    = enable & (cur_state == LOAD);
    assign Enable_C  = enable & (cur_state == COUNT);
    assign Clear_Reg = enable & (cur_state == CLEAR);
    assign cnt_value = (cur_state == LOAD) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            prio_b    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                occupancy <= occupancy + CNT_ONE;
            end else if (pop && !push) begin
                occupancy <= occupancy - CNT_ONE;
            end
            // Priority only rotates when both requesters competed for the grant.
            if (push && req_a && req_b) begin
                prio_b <= ~prio_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
        end else if (enable) begin
            case (cur_state)
                IDLE:    if (!empty) cur_state <= LOAD;
                LOAD:    cur_state <= COUNT;
                COUNT:   if (cnt_zero) cur_state <= CLEAR;
                // No pop happens in CLEAR, so a same-cycle push is enough to chain jobs.
                CLEAR:   cur_state <= (!empty || push) ? LOAD : IDLE;
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/modulo_escalonador_contador.md
Name: modulo_escalonador_contador

Overview:
- Scheduler in front of the loadable counter and its control path.
- Two requesters submit preset values through a round-robin arbiter into a DEPTH-entry request buffer.
- A 4-state Moore FSM pops one entry at a time and sequences the counter: load (Load_C), count until terminal (Enable_C), then clear the holding register (Clear_Reg).
- Replaces the single-source load path so that several producers can share one counter.

Parameters:
WIDTH, 8, bit width of preset values and cnt_value
DEPTH, 4, buffer entries; power of two, minimum 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
enable  input  1  global advance enable; 0 freezes all state
req_a  input  1  requester A has a preset pending
data_a  input  WIDTH  requester A preset value
ack_a  output  1  A's request accepted this cycle
req_b  input  1  requester B has a preset pending
data_b  input  WIDTH  requester B preset value
ack_b  output  1  B's request accepted this cycle
cnt_zero  input  1  counter terminal-count flag (counter value == 0)
Load_C  output  1  counter parallel-load strobe
Enable_C  output  1  counter count enable
Clear_Reg  output  1  clear of the preset holding register
cnt_value  output  WIDTH  preset driven to the counter load input
full  output  1  buffer holds DEPTH entries
empty  output  1  buffer holds 0 entries
state  output  2  FSM state code, for debug

Behaviour:
Reset (rst=0, asynchronous):
- FSM goes to IDLE; pointers, occupancy and storage are cleared to 0; priority goes to A.
- Outputs while in reset: ack_a=ack_b=Load_C=Enable_C=Clear_Reg=0, cnt_value=0, empty=1, full=0, state=00.
- Reset mid-operation discards all buffered entries and the job in progress.

Arbiter (combinational ack, registered push):
- Accept is enabled only when enable=1 and full=0; ack=0 for both requesters otherwise.
- If only one req is high, that requester is acked.
- If both are high, the priority holder is acked and priority flips to the other requester. Priority changes only on a contested grant.
- On the rising edge of an acked cycle, the acked requester's data is written to mem[wr_ptr] and wr_ptr increments (mod DEPTH).
- A requester holds req and data until it sees ack. If req is still high in the cycle after ack, that is a new request.
- full is evaluated on current occupancy, so a push is blocked while full even if a pop occurs in the same cycle.

FSM (state code / decoded outputs, gated by enable):
- IDLE 00: all strobes 0. If empty=0, go to LOAD.
- LOAD 01: Load_C=1 and cnt_value=mem[rd_ptr] for exactly one cycle. Pop at the edge (rd_ptr+1). Go to COUNT.
- COUNT 10: Enable_C=1. Stay while cnt_zero=0; go to CLEAR on the first edge with cnt_zero=1. A preset of 0 therefore gives a 1-cycle COUNT.
- CLEAR 11: Clear_Reg=1 for one cycle. Go to LOAD if empty=0 (occupancy after any same-cycle push), else go to IDLE.
- cnt_value = 0 outside LOAD.

Occupancy and latency:
- Occupancy changes +1 on push, -1 on pop, and is unchanged on a simultaneous push and pop.
- Latency from an ack into an empty buffer with the FSM in IDLE: Load_C asserts 2 cycles after the ack cycle (push edge, then IDLE→LOAD edge).
- Minimum job length is 3 cycles (LOAD, COUNT, CLEAR). Back-to-back jobs have no IDLE gap.

enable=0:
- FSM state, pointers, occupancy and priority all hold.
- Load_C, Enable_C, Clear_Reg, ack_a and ack_b are forced to 0.
- state, full and empty still reflect the held values.

Test Plan:
- Reset, then single push: rst released, req_a=1 with data_a=5 for one cycle -> ack_a=1 in the same cycle; Load_C=1 two cycles later with cnt_value=5; Enable_C high until the bench's counter asserts cnt_zero after 5 counts; Clear_Reg one cycle; return to IDLE with empty=1.
- Contested arbitration: req_a and req_b held high with data 3 and 7 while the FSM is busy -> acks go A, B, A, B on successive accepts; the buffer pops 3,7,3,7 in order.
- Full boundary: 4 pushes while FSM is stalled in COUNT (cnt_zero=0) -> full=1, further req gets ack=0; first pop at LOAD re-enables ack in the cycle after the pop.
- Zero preset: push 0 -> COUNT lasts exactly 1 cycle, Clear_Reg next cycle. Two queued jobs run LOAD→COUNT→CLEAR→LOAD with no IDLE.
- enable freeze: drop enable mid-COUNT for 3 cycles -> Enable_C=0 and state=10 held; no acks despite req; resume with the identical remaining sequence.
- Async reset mid-job: assert rst during COUNT with 2 entries buffered -> outputs 0 immediately (before the next clock edge), empty=1, state=00; the next accepted request after release goes to A when both reqs are high.
